// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction-memory interface. It accepts a byte stream
//   over a valid/ready handshake and packs every 4 bytes into a little-endian
//   32-bit word, with the first byte in the LSB. Each word is written to
//   consecutive word addresses starting at 0. The core fetch enable (cpu_en)
//   stays low while loading and rises once the whole program has been written.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, highest priority
//   start      : one-cycle load request, honoured only in IDLE or DONE
//   len        : number of words to load, latched on an accepted start
//   byte_valid : byte_data carries a program byte this cycle
//   byte_data  : incoming program byte
//   byte_ready : loader can take a byte (registered)
//   mem_we     : instruction-memory write strobe, one cycle per word
//   mem_addr   : word address of the write
//   mem_wdata  : assembled 32-bit instruction word
//   cpu_en     : fetch enable to the core, high only in DONE
//   busy       : high while collecting bytes or writing a word
//   done       : high in DONE
//   err        : sticky flag, set when a start carries len > DEPTH
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_t              state_r;
  state_t              next_state_s;

  logic [1:0]          byte_cnt_r;
  logic [ADDR_W:0]     word_cnt_r;
  logic [ADDR_W:0]     len_r;
  logic [23:0]         word_r;      // bytes 0..2 of the word being assembled
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic                err_r;

  logic                byte_ready_r;
  logic                mem_we_r;
  logic                cpu_en_r;
  logic                busy_r;
  logic                done_r;

  logic                start_seen_s;
  logic                len_bad_s;
  logic                accept_s;
  logic                last_byte_s;
  logic                last_word_s;
  logic [ADDR_W:0]     word_cnt_inc_s;

  logic                byte_ready_s;
  logic                mem_we_s;
  logic                busy_s;
  logic                done_s;

  // A start is only looked at when no load is in flight.
  assign start_seen_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign len_bad_s      = (len > DEPTH_L);
  assign accept_s       = (state_r == S_COLLECT) && byte_valid && byte_ready_r;
  assign last_byte_s    = (byte_cnt_r == 2'd3);
  assign word_cnt_inc_s = word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word_s    = (word_cnt_inc_s == len_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_seen_s) begin
          if (len_bad_s) begin
            next_state_s = S_IDLE;
          end else if (len == {(ADDR_W+1){1'b0}}) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_COLLECT;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      S_COLLECT: begin
        if (accept_s && last_byte_s) begin
          next_state_s = S_WRITE;
        end else begin
          next_state_s = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (last_word_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_COLLECT;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops below present
  // outputs that line up with the state they describe.
  always_comb begin
    byte_ready_s = 1'b0;
    mem_we_s     = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    case (next_state_s)
      S_COLLECT: begin
        byte_ready_s = 1'b1;
        busy_s       = 1'b1;
      end
      S_WRITE: begin
        mem_we_s = 1'b1;
        busy_s   = 1'b1;
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        byte_ready_s = 1'b0;
        mem_we_s     = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
      end
    endcase
  end

  // Output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cpu_en_r     <= 1'b0;
    end else begin
      byte_ready_r <= byte_ready_s;
      mem_we_r     <= mem_we_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      cpu_en_r     <= done_s;
    end
  end

  // Datapath: length latch, counters, byte packing, write address/data, err.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r  <= 2'd0;
      word_cnt_r  <= {(ADDR_W+1){1'b0}};
      len_r       <= {(ADDR_W+1){1'b0}};
      word_r      <= 24'd0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      if (start_seen_s) begin
        if (len_bad_s) begin
          err_r <= 1'b1;
        end else begin
          err_r      <= 1'b0;
          len_r      <= len;
          word_cnt_r <= {(ADDR_W+1){1'b0}};
          byte_cnt_r <= 2'd0;
        end
      end

      if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0: word_r[7:0]   <= byte_data;
          2'd1: word_r[15:8]  <= byte_data;
          2'd2: word_r[23:16] <= byte_data;
          default: begin
            // Fourth byte goes straight into the write data.
            mem_addr_r  <= word_cnt_r[ADDR_W-1:0];
            mem_wdata_r <= {byte_data, word_r};
          end
        endcase
      end

      if (state_r == S_WRITE) begin
        word_cnt_r <= word_cnt_inc_s;
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_en     = cpu_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Program bytes are held in an array;
//   the expected word i is simply bytes 4i..4i+3 packed little-endian and its
//   expected address is i. Every write must appear exactly one cycle after
//   the byte that completes its word.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_en;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prog [0:127];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_en     (cpu_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {prog[4*w+3], prog[4*w+2], prog[4*w+1], prog[4*w]};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_we"},    mem_we,     0);
    chk({tag, "_addr"},  mem_addr,   0);
    chk({tag, "_wdata"}, mem_wdata,  0);
    chk({tag, "_cpu_en"}, cpu_en,    0);
    chk({tag, "_busy"},  busy,       0);
    chk({tag, "_done"},  done,       0);
    chk({tag, "_err"},   err,        0);
  endtask

  // mode 0: valid always high, 1: valid toggles 1,0,1,0, 2: random valid
  // stop_after >= 0 abandons the load once that many bytes were accepted.
  task automatic run_load(input int ln, input int mode, input int stop_after);
    int  idx;
    int  words;
    int  budget;
    bit  tog;
    bit  hs;
    bit  exp_we;
    idx = 0; words = 0; budget = 0; tog = 1'b1;
    start = 1'b1;
    len   = 6'(ln);
    tick();
    start = 1'b0;
    chk("start_busy",   busy,       1);
    chk("start_ready",  byte_ready, 1);
    chk("start_cpu_en", cpu_en,     0);
    chk("start_done",   done,       0);
    chk("start_err",    err,        0);
    while (words < ln && budget < 2000) begin
      if (stop_after >= 0 && idx == stop_after) break;
      case (mode)
        0: byte_valid = 1'b1;
        1: begin byte_valid = tog; tog = !tog; end
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      byte_data = prog[idx];
      // Occasional start pulses during a load must be ignored.
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      len   = 6'd0;
      hs = byte_valid && byte_ready;
      tick();
      byte_valid = 1'b0;
      start      = 1'b0;
      if (hs) idx++;
      exp_we = hs && (idx % 4 == 0);
      chk("we_timing", mem_we, exp_we);
      chk("ready_and_we", mem_we && byte_ready, 0);
      chk("cpu_en_low", cpu_en, 0);
      if (exp_we && mem_we) begin
        chk("wr_addr",  mem_addr,  words);
        chk("wr_data",  mem_wdata, exp_word(words));
        chk("wr_ready", byte_ready, 0);
        chk("wr_busy",  busy,       1);
        words++;
      end
      budget++;
    end
    if (stop_after < 0) begin
      chk("load_timeout", words, ln);
      tick();
      chk("end_done",   done,       1);
      chk("end_cpu_en", cpu_en,     1);
      chk("end_busy",   busy,       0);
      chk("end_ready",  byte_ready, 0);
      chk("end_we",     mem_we,     0);
      chk("end_err",    err,        0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = 8'h00;
    for (int i = 0; i < 128; i++) prog[i] = 8'h00;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all_zero("idle");
    end

    // Two-word load, continuous and toggled valid
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
    run_load(2, 0, -1);
    run_load(2, 1, -1);

    // Rejected length, then empty load
    start = 1'b1; len = 6'd33;
    tick();
    start = 1'b0;
    chk("bad_len_err",    err,    1);
    chk("bad_len_busy",   busy,   0);
    chk("bad_len_done",   done,   0);
    chk("bad_len_cpu_en", cpu_en, 0);
    for (int c = 0; c < 3; c++) begin
      byte_valid = 1'b1;
      tick();
      chk("bad_len_we",    mem_we,     0);
      chk("bad_len_ready", byte_ready, 0);
      chk("bad_len_stick", err,        1);
    end
    byte_valid = 1'b0;
    start = 1'b1; len = 6'd0;
    tick();
    start = 1'b0;
    chk("zero_done",   done,   1);
    chk("zero_cpu_en", cpu_en, 1);
    chk("zero_err",    err,    0);
    chk("zero_we",     mem_we, 0);
    tick();
    chk("zero_we2",    mem_we, 0);

    // Reset in the middle of word 1 of a three-word load
    for (int i = 0; i < 12; i++) prog[i] = 8'($urandom_range(1, 255));
    run_load(3, 0, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_rst");
    tick();
    check_all_zero("mid_rst_idle");
    for (int i = 0; i < 4; i++) prog[i] = 8'($urandom_range(1, 255));
    run_load(1, 0, -1);

    // Reload straight from DONE
    for (int i = 0; i < 4; i++) prog[i] = 8'($urandom_range(0, 255));
    run_load(1, 0, -1);

    // Random loads with random valid pattern, including the DEPTH boundary
    for (int r = 0; r < 6; r++) begin
      int ln;
      ln = $urandom_range(1, 5);
      for (int i = 0; i < 4 * ln; i++) prog[i] = 8'($urandom_range(0, 255));
      run_load(ln, 2, -1);
    end
    for (int i = 0; i < 128; i++) prog[i] = 8'($urandom_range(0, 255));
    run_load(DEPTH, 2, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the fetch stage is the reader.
- Accepts a byte stream through a valid/ready handshake and packs each group of 4 bytes into a little-endian 32-bit word.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the core's fetch enable low while loading and releases it when the program is fully written.

Parameters:
- ADDR_W, 5, instruction-memory word-address width.
- DEPTH, 32, number of instruction-memory words; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- len  input  ADDR_W+1  number of words to load; latched on an accepted start.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader can accept a byte; registered.
- mem_we  output  1  instruction-memory write strobe; registered, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  assembled instruction word.
- cpu_en  output  1  fetch enable to the core; high only in DONE.
- busy  output  1  high in COLLECT and WRITE.
- done  output  1  high in DONE.
- err  output  1  sticky; set on a rejected len; cleared by rst or by the next accepted start.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - State goes to IDLE.
  - byte_ready, mem_we, cpu_en, busy, done and err all go to 0.
  - mem_addr, mem_wdata, the byte counter and the word counter all go to 0.
  - rst has priority over every other input.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE, on start=1:
  - len > DEPTH: set err=1 and stay in IDLE.
  - len == 0: go to DONE; no writes occur.
  - Otherwise: latch len, clear err, clear the word counter and byte counter, go to COLLECT, assert byte_ready from the next cycle.
- COLLECT:
  - A byte is accepted when byte_valid && byte_ready at a clock edge.
  - Byte k (k = 0..3) is placed in bits [8k+7:8k] of the word, i.e. the first byte received is the LSB.
  - byte_valid while byte_ready=0 is ignored; no byte is consumed.
  - On acceptance of the 4th byte: go to WRITE and deassert byte_ready in the same edge.
- WRITE:
  - mem_we=1 for exactly one cycle, with mem_addr = word counter and mem_wdata = assembled word.
  - Latency: 4th byte accepted at edge N → mem_we high during cycle N+1.
  - After the write, the word counter increments.
  - If the new word count equals len: go to DONE. Otherwise: go to COLLECT and reassert byte_ready.
  - Minimum throughput is 5 cycles per word.
- DONE:
  - done=1 and cpu_en=1; busy=0 and byte_ready=0.
  - A new start re-enters the IDLE start logic in the same cycle, so cpu_en drops the following cycle (reload support).
- start is ignored in COLLECT and WRITE.
- Word-counter wrap: not possible, because len ≤ DEPTH is enforced.
- Reset mid-load:
  - Any partial word is discarded.
  - Words already written stay in memory.
  - cpu_en stays 0 until a new load completes.
- byte_ready is never high in the same cycle as mem_we.
- mem_we is never high outside WRITE.

Test Plan:
- Reset, then idle 3 cycles → all outputs 0; cpu_en=0.
- start with len=2, then stream bytes 13,00,00,00,93,00,10,00 (hex) with continuous valid → mem_we pulses at addr 0 with 0x00000013 and at addr 1 with 0x00100093; each pulse 1 cycle after its 4th byte; done=1 and cpu_en=1 one cycle after the second write.
- Same load with byte_valid toggled 1,0,1,0 → same words and addresses; no byte lost or duplicated; no write before the 4th accepted byte.
- start with len=33 (DEPTH=32) → err=1, state stays IDLE, no mem_we. Then start with len=0 → done=1, cpu_en=1, err=0, no writes.
- Assert rst after 2 bytes of word 1 in a len=3 load → all outputs 0 next cycle. A fresh len=1 load then writes addr 0 with the new bytes only.
- From DONE, pulse start with len=1 → cpu_en drops 1 cycle later; busy=1; after 4 bytes, addr 0 is rewritten and cpu_en rises again.
